// File: rtl/comp_mult_if.sv
// Operand/result handshake bundle for comp_mult: valid/ready on both sides.
// op_data = {x1,y1,x2,y2}; res_data = {xr,yr}, each result field 2*DWIDTH+2 bits.
interface comp_mult_if #(
    parameter int DWIDTH = 8
);
    logic                    op_val;
    logic                    op_rdy;
    logic [4*DWIDTH-1:0]     op_data;
    logic                    res_val;
    logic                    res_rdy;
    logic [4*(DWIDTH+1)-1:0] res_data;

    modport master (
        output op_val, op_data, res_rdy,
        input  op_rdy, res_val, res_data
    );

    modport slave (
        input  op_val, op_data, res_rdy,
        output op_rdy, res_val, res_data
    );
endinterface

// File: rtl/comp_mult.sv
// Signed complex multiply (x1 + j*y1) * (x2 + j*y2) using NO_MULT multipliers; one op in flight.
// Latency: res_val first high 4/NO_MULT cycles after the accept cycle; result held until res_rdy.
// Backpressure: op_rdy only in IDLE; with COMP_MULT_BACK2BACK_EN also in DONE when res_rdy is high.
module comp_mult #(
    parameter int DWIDTH  = 8,
    parameter int NO_MULT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst,
    comp_mult_if.slave bus
);
    localparam int N  = (NO_MULT == 4) ? 1 : (NO_MULT == 2) ? 2 : 4;
    localparam int PW = 2 * DWIDTH;
    localparam int AW = 2 * DWIDTH + 2;

    if (NO_MULT != 1 && NO_MULT != 2 && NO_MULT != 4) begin : g_bad_no_mult
        $fatal(1, "%m: NO_MULT=%0d is illegal, must be 1, 2 or 4", NO_MULT);
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state;
    logic                    op_rdy_q;
    logic                    res_val_q;
    logic [1:0]              cnt;
    logic [4*DWIDTH-1:0]     op_q;
    logic signed [AW-1:0]    acc_x, acc_y;
    logic [2*AW-1:0]         res_q;

    logic                    accept;
    logic                    advance;
    logic                    last;
    logic [1:0]              step;
    logic [4*DWIDTH-1:0]     src;
    logic signed [DWIDTH-1:0] x1, y1, x2, y2;
    logic signed [PW-1:0]    prod [NO_MULT];
    logic [1:0]              pidx [NO_MULT];
    logic signed [AW-1:0]    nxt_x, nxt_y;

`ifdef COMP_MULT_BACK2BACK_EN
    assign bus.op_rdy = op_rdy_q | (res_val_q & bus.res_rdy);
`else
    assign bus.op_rdy = op_rdy_q;
`endif
    assign bus.res_val  = res_val_q;
    assign bus.res_data = res_q;

    // The accept edge is the first product step, so operands come straight from the bus then.
    assign accept  = bus.op_val & bus.op_rdy;
    assign advance = accept | (state == CALC);
    assign step    = accept ? 2'd0 : cnt;
    assign last    = (step == 2'(N - 1));
    assign src     = accept ? bus.op_data : op_q;

    assign x1 = src[4*DWIDTH-1 -: DWIDTH];
    assign y1 = src[3*DWIDTH-1 -: DWIDTH];
    assign x2 = src[2*DWIDTH-1 -: DWIDTH];
    assign y2 = src[DWIDTH-1:0];

    // Lane j at step s computes product index s*NO_MULT + j: p0=x1*x2, p1=y1*y2, p2=x1*y2, p3=y1*x2.
    for (genvar j = 0; j < NO_MULT; j++) begin : g_lane
        logic signed [DWIDTH-1:0] ma, mb;

        assign pidx[j] = 2'(int'(step) * NO_MULT + j);

        always_comb begin
            case (pidx[j])
                2'd0:    begin ma = x1; mb = x2; end
                2'd1:    begin ma = y1; mb = y2; end
                2'd2:    begin ma = x1; mb = y2; end
                default: begin ma = y1; mb = x2; end
            endcase
        end

        assign prod[j] = ma * mb;
    end

    always_comb begin
        nxt_x = accept ? '0 : acc_x;
        nxt_y = accept ? '0 : acc_y;
        for (int j = 0; j < NO_MULT; j++) begin
            case (pidx[j])
                2'd0:    nxt_x = nxt_x + AW'(prod[j]);
                2'd1:    nxt_x = nxt_x - AW'(prod[j]);
                default: nxt_y = nxt_y + AW'(prod[j]);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_rdy_q  <= 1'b1;
            res_val_q <= 1'b0;
            cnt       <= 2'd0;
            op_q      <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            res_q     <= '0;
        end else if (sw_rst) begin
            state     <= IDLE;
            op_rdy_q  <= 1'b1;
            res_val_q <= 1'b0;
            cnt       <= 2'd0;
            op_q      <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            res_q     <= '0;
        end else if (advance) begin
            if (accept) begin
                op_q <= bus.op_data;
            end
            op_rdy_q <= 1'b0;
            if (last) begin
                state     <= DONE;
                res_val_q <= 1'b1;
                cnt       <= 2'd0;
                res_q     <= {nxt_x, nxt_y};
            end else begin
                state     <= CALC;
                res_val_q <= 1'b0;
                cnt       <= step + 2'd1;
                acc_x     <= nxt_x;
                acc_y     <= nxt_y;
            end
        end else if (state == DONE && bus.res_rdy) begin
            state     <= IDLE;
            res_val_q <= 1'b0;
            op_rdy_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_comp_mult.sv
// Bench for comp_mult: three instances (NO_MULT 1, 2, 4) driven with directed vectors;
// expected results are queued at issue time and popped by an independent result monitor.
module tb_comp_mult;
    localparam int DW = 8;
    localparam int RW = 4 * (DW + 1);
`ifdef COMP_MULT_BACK2BACK_EN
    localparam int PERIOD = 2;
`else
    localparam int PERIOD = 3;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      sw_rst;
    logic [2:0]      op_val;
    logic [2:0]      res_rdy;
    logic [4*DW-1:0] op_data [3];
    logic [2:0]      op_rdy_w;
    logic [2:0]      res_val_w;
    logic [RW-1:0]   res_data_w [3];

    int total = 0;
    int bad   = 0;

    logic [RW-1:0] expq0[$];
    logic [RW-1:0] expq1[$];
    logic [RW-1:0] expq2[$];
    logic [RW-1:0] mon_exp;
    int            mon_n;

    // Hand-computed vectors: xr = x1*x2 - y1*y2, yr = x1*y2 + y1*x2.
    int vx1 [7] = '{3, -128, -128, 127, -1,  127, -128};
    int vy1 [7] = '{4, -128,  127, 127,  2, -128, -128};
    int vx2 [7] = '{5, -128, -128, 127,  3,  127,  127};
    int vy2 [7] = '{6, -128, -128, 127, -4, -128, -128};
    int vxr [7] = '{-9,    0, 32640,     0, 5,   -255, -32640};
    int vyr [7] = '{38, 32768,  128, 32258, 10, -32512,    128};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        comp_mult_if #(.DWIDTH(DW)) bus ();

        assign bus.op_val     = op_val[g];
        assign bus.op_data    = op_data[g];
        assign bus.res_rdy    = res_rdy[g];
        assign op_rdy_w[g]    = bus.op_rdy;
        assign res_val_w[g]   = bus.res_val;
        assign res_data_w[g]  = bus.res_data;

        comp_mult #(.DWIDTH(DW), .NO_MULT(1 << g)) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_rst (sw_rst[g]),
            .bus    (bus.slave)
        );
    end

    function automatic logic [4*DW-1:0] pack_op(input int i);
        return {8'(vx1[i]), 8'(vy1[i]), 8'(vx2[i]), 8'(vy2[i])};
    endfunction

    function automatic logic [RW-1:0] pack_res(input int i);
        return {18'(vxr[i]), 18'(vyr[i])};
    endfunction

    function automatic void push(input int d, input logic [RW-1:0] v);
        case (d)
            0:       expq0.push_back(v);
            1:       expq1.push_back(v);
            default: expq2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return expq0.size();
            1:       return expq1.size();
            default: return expq2.size();
        endcase
    endfunction

    function automatic logic [RW-1:0] qpop(input int d);
        case (d)
            0:       return expq0.pop_front();
            1:       return expq1.pop_front();
            default: return expq2.pop_front();
        endcase
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h exp=%0h", name, d, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int d);
        total++;
        bad++;
        $display("FAIL %s dut%0d got=timeout exp=event", name, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int d);
        int c = 0;
        while (!op_rdy_w[d] && c < 20) begin
            tick();
            c++;
        end
        if (c >= 20) timeout("wait_op_rdy", d);
    endtask

    task automatic wait_res(input int d);
        int c = 0;
        while (!res_val_w[d] && c < 20) begin
            tick();
            c++;
        end
        if (c >= 20) timeout("wait_res_val", d);
    endtask

    task automatic start_op(input int d, input int i, input bit do_push, input logic rdy);
        wait_rdy(d);
        op_data[d] = pack_op(i);
        op_val[d]  = 1'b1;
        res_rdy[d] = rdy;
        if (do_push) push(d, pack_res(i));
        tick();
        op_val[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input int i);
        start_op(d, i, 1'b1, 1'b1);
        wait_res(d);
        tick();
    endtask

    // Result monitor: every result handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (res_val_w[d] && res_rdy[d]) begin
                mon_n = qsize(d);
                total++;
                if (mon_n == 0) begin
                    bad++;
                    $display("FAIL res_unexpected dut%0d got=%h exp=none", d, res_data_w[d]);
                end else begin
                    mon_exp = qpop(d);
                    if (res_data_w[d] !== mon_exp) begin
                        bad++;
                        $display("FAIL res_data dut%0d got=%h exp=%h", d, res_data_w[d], mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, nacc, nres, cyc, last_cyc;
        logic acc, rv;

        rst_n   = 1'b0;
        sw_rst  = '0;
        op_val  = '0;
        res_rdy = '0;
        for (int d = 0; d < 3; d++) op_data[d] = '0;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset_op_rdy", d, 64'(op_rdy_w[d]), 64'd1);
            chk("reset_res_val", d, 64'(res_val_w[d]), 64'd0);
            chk("reset_res_data", d, 64'(res_data_w[d]), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // Latency: accept in cycle 0, res_val first high in cycle 4/NO_MULT, for one cycle.
        for (int d = 0; d < 3; d++) begin
            start_op(d, 0, 1'b1, 1'b1);
            lat = 1;
            while (!res_val_w[d] && lat < 20) begin
                tick();
                lat++;
            end
            chk("latency", d, 64'(lat), 64'(4 >> d));
            tick();
            chk("res_val_pulse", d, 64'(res_val_w[d]), 64'd0);
        end

        for (int d = 0; d < 3; d++)
            for (int i = 1; i < 7; i++) run_op(d, i);

        // Stall with res_rdy low while op_data toggles and op_val stays high.
        for (int d = 0; d < 3; d++) begin
            start_op(d, 2, 1'b1, 1'b0);
            op_val[d]  = 1'b1;
            op_data[d] = pack_op(3);
            wait_res(d);
            for (int k = 0; k < 5; k++) begin
                chk("stall_res_val", d, 64'(res_val_w[d]), 64'd1);
                chk("stall_res_data", d, 64'(res_data_w[d]), 64'(pack_res(2)));
                chk("stall_op_rdy", d, 64'(op_rdy_w[d]), 64'd0);
                op_data[d] = pack_op((k % 2 == 0) ? 4 : 5);
                tick();
            end
            op_val[d]  = 1'b0;
            res_rdy[d] = 1'b1;
            tick();
            chk("post_hs_res_val", d, 64'(res_val_w[d]), 64'd0);
            chk("post_hs_res_data_hold", d, 64'(res_data_w[d]), 64'(pack_res(2)));
            chk("post_hs_op_rdy", d, 64'(op_rdy_w[d]), 64'd1);
            repeat (3) tick();
            chk("no_second_accept", d, 64'(res_val_w[d]), 64'd0);
        end

        // Hardware reset right after accept discards the operation.
        for (int d = 0; d < 3; d++) begin
            start_op(d, 3, 1'b0, 1'b0);
            rst_n = 1'b0;
            #2;
            chk("arst_op_rdy", d, 64'(op_rdy_w[d]), 64'd1);
            chk("arst_res_val", d, 64'(res_val_w[d]), 64'd0);
            rst_n = 1'b1;
            tick();
            chk("arst_next_op_rdy", d, 64'(op_rdy_w[d]), 64'd1);
            chk("arst_next_res_val", d, 64'(res_val_w[d]), 64'd0);
            chk("arst_next_res_data", d, 64'(res_data_w[d]), 64'd0);
            repeat (5) tick();
            chk("arst_no_result", d, 64'(res_val_w[d]), 64'd0);
            run_op(d, 5);
        end

        // Software reset while the result is presented.
        for (int d = 0; d < 3; d++) begin
            start_op(d, 4, 1'b0, 1'b0);
            wait_res(d);
            sw_rst[d] = 1'b1;
            tick();
            sw_rst[d] = 1'b0;
            chk("swrst_op_rdy", d, 64'(op_rdy_w[d]), 64'd1);
            chk("swrst_res_val", d, 64'(res_val_w[d]), 64'd0);
            chk("swrst_res_data", d, 64'(res_data_w[d]), 64'd0);
            repeat (4) tick();
            chk("swrst_no_result", d, 64'(res_val_w[d]), 64'd0);
            run_op(d, 6);
        end

        // Throughput with op_val and res_rdy held high on the NO_MULT=2 instance.
        wait_rdy(1);
        res_rdy[1] = 1'b1;
        nacc = 0;
        nres = 0;
        cyc = 0;
        last_cyc = 0;
        while ((nacc < 10 || nres < 10) && cyc < 100) begin
            if (nacc < 10) begin
                op_val[1]  = 1'b1;
                op_data[1] = pack_op(nacc % 7);
            end else begin
                op_val[1] = 1'b0;
            end
            acc = op_val[1] && op_rdy_w[1];
            rv  = res_val_w[1];
            if (acc) push(1, pack_res(nacc % 7));
            if (rv) begin
                if (nres > 0) chk("b2b_period", 1, 64'(cyc - last_cyc), 64'(PERIOD));
                last_cyc = cyc;
                nres++;
            end
            tick();
            cyc++;
            if (acc) nacc++;
        end
        op_val[1] = 1'b0;
        chk("b2b_result_count", 1, 64'(nres), 64'd10);

        repeat (5) tick();
        for (int d = 0; d < 3; d++) chk("queue_drained", d, 64'(qsize(d)), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
